fetch_queue: RTL and testbench

- Decoupling instruction queue directly downstream of the instruction cache's dual-word response port.
- Accepts up to two instructions per cycle, each response being {inst1, inst0} for pc and pc+4.
- Presents up to two oldest instructions per cycle, in program order, to decode.
- Tracks cache requests in flight so that responses to requests issued before a flush are discarded and space is always reserved for every outstanding response.

---
 rtl/fetch_queue_if.sv | 32 +++
 rtl/fetch_queue.sv | 134 +++++++++++++
 tb/tb_fetch_queue.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Bundle of the fetch_queue response, request-credit and decode-side signals.
// slave is the queue itself; master is the cache/decode environment driving it.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          req_fire;
  logic          req_ready;
  logic          rsp_valid;
  logic [31:0]   rsp_pc;
  logic [63:0]   rsp_data;
  logic [1:0]    rsp_mask;
  logic [1:0]    out_valid;
  logic [31:0]   out_pc_0;
  logic [31:0]   out_inst_0;
  logic [31:0]   out_pc_1;
  logic [31:0]   out_inst_1;
  logic [1:0]    out_deq;
  logic [CW-1:0] count;

  modport master (
    output flush, req_fire, rsp_valid, rsp_pc, rsp_data, rsp_mask, out_deq,
    input  req_ready, out_valid, out_pc_0, out_inst_0, out_pc_1, out_inst_1, count
  );

  modport slave (
    input  flush, req_fire, rsp_valid, rsp_pc, rsp_data, rsp_mask, out_deq,
    output req_ready, out_valid, out_pc_0, out_inst_0, out_pc_1, out_inst_1, count
  );
endinterface

// File: rtl/fetch_queue.sv
// Dual-issue instruction fetch queue with in-flight request credit and flush dropping.
// Define FETCH_QUEUE_BYPASS_EN to forward a response straight to decode when the queue is empty.
module fetch_queue #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input logic        clk,
  input logic        resetn,
  fetch_queue_if.slave bus
);
  localparam int unsigned PW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = PW - 1;
  localparam int unsigned FW = $clog2(MAX_INFLIGHT + 1) + 1;
  localparam int unsigned DW = FW + 2;
  localparam int unsigned RW = PW + FW + 2;

  logic [PW-1:0] head, tail, occ;
  logic [IW-1:0] head_idx, head1_idx, tail_idx, tail1_idx;
  logic [31:0]   pc_mem   [DEPTH];
  logic [31:0]   inst_mem [DEPTH];
  logic [FW-1:0] inflight;
  logic [DW-1:0] drop;

  logic          enq;
  logic          bypass;
  logic [1:0]    enq_n, avail, deq_n;
  logic [31:0]   w0_pc, w0_inst, w1_pc, w1_inst;
  logic [RW-1:0] need;

  always_comb begin
    occ       = tail - head;
    head_idx  = head[IW-1:0];
    head1_idx = head[IW-1:0] + IW'(1);
    tail_idx  = tail[IW-1:0];
    tail1_idx = tail[IW-1:0] + IW'(1);

    enq   = bus.rsp_valid && (drop == '0);
    enq_n = {1'b0, bus.rsp_mask[0]} + {1'b0, bus.rsp_mask[1]};

    // Compact the response: the first valid instruction always lands in slot 0.
    if (bus.rsp_mask[0]) begin
      w0_pc   = bus.rsp_pc;
      w0_inst = bus.rsp_data[31:0];
    end else begin
      w0_pc   = bus.rsp_pc + 32'd4;
      w0_inst = bus.rsp_data[63:32];
    end
    w1_pc   = bus.rsp_pc + 32'd4;
    w1_inst = bus.rsp_data[63:32];

`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = (occ == '0) && enq;
`else
    bypass = 1'b0;
`endif

    bus.out_pc_0   = '0;
    bus.out_inst_0 = '0;
    bus.out_pc_1   = '0;
    bus.out_inst_1 = '0;
    if (bypass) begin
      avail          = enq_n;
      bus.out_pc_0   = w0_pc;
      bus.out_inst_0 = w0_inst;
      if (enq_n == 2'd2) begin
        bus.out_pc_1   = w1_pc;
        bus.out_inst_1 = w1_inst;
      end
    end else begin
      avail = (occ >= PW'(2)) ? 2'd2 : occ[1:0];
      if (avail != 2'd0) begin
        bus.out_pc_0   = pc_mem[head_idx];
        bus.out_inst_0 = inst_mem[head_idx];
      end
      if (avail == 2'd2) begin
        bus.out_pc_1   = pc_mem[head1_idx];
        bus.out_inst_1 = inst_mem[head1_idx];
      end
    end
    bus.out_valid = {avail == 2'd2, avail != 2'd0};
    deq_n         = (bus.out_deq > avail) ? avail : bus.out_deq;

    // Reserve two slots for every outstanding request plus the one about to issue.
    need          = RW'(occ) + (RW'(inflight) << 1) + RW'(2);
    bus.req_ready = (need <= RW'(DEPTH)) && (inflight < FW'(MAX_INFLIGHT));
    bus.count     = occ;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head     <= '0;
      tail     <= '0;
      inflight <= '0;
      drop     <= '0;
    end else if (bus.flush) begin
      head     <= '0;
      tail     <= '0;
      drop     <= drop + DW'(inflight) - DW'(bus.rsp_valid);
      inflight <= FW'(bus.req_fire);
    end else begin
      if (bus.rsp_valid && (drop != '0))
        drop <= drop - DW'(1);
      inflight <= inflight + FW'(bus.req_fire) - FW'(bus.rsp_valid && (drop == '0));
      if (enq)
        tail <= tail + PW'(enq_n);
      // A bypassed-and-consumed instruction is written then retired by head in the same edge.
      head <= head + PW'(deq_n);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && !bus.flush && enq) begin
      if (enq_n != 2'd0) begin
        pc_mem[tail_idx]   <= w0_pc;
        inst_mem[tail_idx] <= w0_inst;
      end
      if (enq_n == 2'd2) begin
        pc_mem[tail1_idx]   <= w1_pc;
        inst_mem[tail1_idx] <= w1_inst;
      end
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (resetn) begin
      assert (bus.out_deq <= avail)
        else $error("fetch_queue: out_deq exceeds visible entries");
      assert (bus.flush || !enq || (int'(occ) + int'(enq_n) - int'(deq_n) <= int'(DEPTH)))
        else $error("fetch_queue: enqueue overflows storage");
    end
  end
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed vector table, hand sequences, then
// randomized traffic against a queue-based reference model.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned MAX   = 2;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH), .MAX_INFLIGHT(MAX)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input logic fl, input logic rf, input logic rv, input logic [31:0] pc,
                       input logic [63:0] data, input logic [1:0] mask, input logic [1:0] deq);
    bus.flush     = fl;
    bus.req_fire  = rf;
    bus.rsp_valid = rv;
    bus.rsp_pc    = pc;
    bus.rsp_data  = data;
    bus.rsp_mask  = mask;
    bus.out_deq   = deq;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    drive(0, 0, 0, '0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset count", 64'(bus.count), 0);
    check("reset out_valid", 64'(bus.out_valid), 0);
    check("reset req_ready", 64'(bus.req_ready), 1);
    check("reset out_pc_0", 64'(bus.out_pc_0), 0);
    check("reset out_inst_0", 64'(bus.out_inst_0), 0);
    check("reset out_pc_1", 64'(bus.out_pc_1), 0);
    check("reset out_inst_1", 64'(bus.out_inst_1), 0);
    resetn = 1'b1;
  endtask

  typedef struct {
    logic        fl, rf, rv;
    logic [31:0] pc;
    logic [63:0] data;
    logic [1:0]  mask, deq;
    logic [3:0]  e_cnt;
    logic [1:0]  e_val;
    logic        e_rdy, chk;
    logic [31:0] e_pc0, e_in0, e_pc1, e_in1;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic fl, input logic rf, input logic rv, input logic [31:0] pc,
                              input logic [63:0] data, input logic [1:0] mask, input logic [1:0] deq,
                              input logic [3:0] cnt, input logic [1:0] val, input logic rdy, input logic chk,
                              input logic [31:0] pc0, input logic [31:0] in0, input logic [31:0] pc1,
                              input logic [31:0] in1);
    vec_t v;
    v.fl = fl; v.rf = rf; v.rv = rv; v.pc = pc; v.data = data; v.mask = mask; v.deq = deq;
    v.e_cnt = cnt; v.e_val = val; v.e_rdy = rdy; v.chk = chk;
    v.e_pc0 = pc0; v.e_in0 = in0; v.e_pc1 = pc1; v.e_in1 = in1;
    tbl.push_back(v);
  endfunction

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;
  ent_t mq[$];
  ent_t rl[$];
  ent_t vis[$];
  ent_t e;
  int   m_infl, m_drop, nvis;
  logic r_fl, r_rf, r_rv, r_enq, r_rdy;
  logic [31:0] r_pc;
  logic [63:0] r_data;
  logic [1:0]  r_mask, r_deq;

  initial begin
    do_reset();

    // fl rf rv pc data mask deq | count valid ready chk pc0 inst0 pc1 inst1
    add(0,0,0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    add(0,0,1,32'hBFC00000,64'h24020002_24010001,2'b11,0, 0,0,1,0, 0,0,0,0);
    add(0,0,0,0,0,0,0, 2,3,1,1, 32'hBFC00000,32'h24010001,32'hBFC00004,32'h24020002);
    add(0,0,0,0,0,0,2, 2,3,1,1, 32'hBFC00000,32'h24010001,32'hBFC00004,32'h24020002);
    add(0,1,0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    add(0,0,1,32'h1000,64'h8C430000_DEADBEEF,2'b10,0, 0,0,1,0, 0,0,0,0);
    add(0,0,0,0,0,0,0, 1,1,1,1, 32'h1004,32'h8C430000,0,0);
    add(0,0,0,0,0,0,1, 1,1,1,1, 32'h1004,32'h8C430000,0,0);
    add(0,1,0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    add(0,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0);
    add(0,0,1,32'h2000,64'h11_00000010,2'b11,0, 0,0,0,0, 0,0,0,0);
    add(0,0,1,32'h2008,64'h13_00000012,2'b11,0, 2,3,1,1, 32'h2000,32'h10,32'h2004,32'h11);
    add(0,1,0,0,0,0,0, 4,3,1,1, 32'h2000,32'h10,32'h2004,32'h11);
    add(0,0,0,0,0,0,0, 4,3,1,1, 32'h2000,32'h10,32'h2004,32'h11);
    add(0,0,1,32'h2010,64'h15_00000014,2'b11,0, 4,3,1,1, 32'h2000,32'h10,32'h2004,32'h11);
    add(0,1,0,0,0,0,0, 6,3,1,1, 32'h2000,32'h10,32'h2004,32'h11);
    add(0,0,0,0,0,0,0, 6,3,0,1, 32'h2000,32'h10,32'h2004,32'h11);
    add(0,0,1,32'h2018,64'h17_00000016,2'b11,0, 6,3,0,1, 32'h2000,32'h10,32'h2004,32'h11);
    add(0,1,0,0,0,0,0, 8,3,0,1, 32'h2000,32'h10,32'h2004,32'h11);
    add(0,0,1,32'h2020,64'h19_00000018,2'b11,2, 8,3,0,1, 32'h2000,32'h10,32'h2004,32'h11);
    add(0,0,0,0,0,0,0, 8,3,0,1, 32'h2008,32'h12,32'h200C,32'h13);
    add(0,0,0,0,0,0,2, 8,3,0,1, 32'h2008,32'h12,32'h200C,32'h13);
    add(0,0,0,0,0,0,2, 6,3,1,1, 32'h2010,32'h14,32'h2014,32'h15);
    add(0,0,0,0,0,0,2, 4,3,1,1, 32'h2018,32'h16,32'h201C,32'h17);
    add(0,0,0,0,0,0,2, 2,3,1,1, 32'h2020,32'h18,32'h2024,32'h19);
    add(0,0,0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    add(1,0,0,0,0,0,0, 0,0,0,1, 0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    add(0,0,1,32'h3000,64'hAA_000000BB,2'b11,0, 0,0,1,1, 0,0,0,0);
    add(0,0,1,32'h3008,64'hCC_000000DD,2'b11,0, 0,0,1,1, 0,0,0,0);
    add(0,0,0,0,0,0,0, 0,0,1,1, 0,0,0,0);
    add(0,0,1,32'h4000,64'hDEAD_00000044,2'b01,0, 0,0,1,0, 0,0,0,0);
    add(0,0,0,0,0,0,0, 1,1,1,1, 32'h4000,32'h44,0,0);
    add(1,0,0,0,0,0,1, 1,1,1,1, 32'h4000,32'h44,0,0);
    add(0,0,0,0,0,0,0, 0,0,1,1, 0,0,0,0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].fl, tbl[i].rf, tbl[i].rv, tbl[i].pc, tbl[i].data, tbl[i].mask, tbl[i].deq);
      #1;
      check($sformatf("row%0d count", i), 64'(bus.count), 64'(tbl[i].e_cnt));
      check($sformatf("row%0d req_ready", i), 64'(bus.req_ready), 64'(tbl[i].e_rdy));
      if (tbl[i].chk) begin
        check($sformatf("row%0d out_valid", i), 64'(bus.out_valid), 64'(tbl[i].e_val));
        check($sformatf("row%0d out_pc_0", i), 64'(bus.out_pc_0), 64'(tbl[i].e_pc0));
        check($sformatf("row%0d out_inst_0", i), 64'(bus.out_inst_0), 64'(tbl[i].e_in0));
        check($sformatf("row%0d out_pc_1", i), 64'(bus.out_pc_1), 64'(tbl[i].e_pc1));
        check($sformatf("row%0d out_inst_1", i), 64'(bus.out_inst_1), 64'(tbl[i].e_in1));
      end
    end

    // Response into an empty queue: same-cycle visibility only with the bypass build.
    @(negedge clk);
    drive(0, 1, 0, '0, '0, '0, '0);
    @(negedge clk);
`ifdef FETCH_QUEUE_BYPASS_EN
    drive(0, 0, 1, 32'h5000, 64'h51_00000050, 2'b11, 2'd1);
    #1;
    check("bypass out_valid", 64'(bus.out_valid), 3);
    check("bypass out_pc_0", 64'(bus.out_pc_0), 32'h5000);
    check("bypass out_inst_0", 64'(bus.out_inst_0), 32'h50);
    check("bypass out_inst_1", 64'(bus.out_inst_1), 32'h51);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0, '0);
    #1;
    check("bypass next count", 64'(bus.count), 1);
    check("bypass next out_pc_0", 64'(bus.out_pc_0), 32'h5004);
    check("bypass next out_inst_0", 64'(bus.out_inst_0), 32'h51);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0, 2'd1);
`else
    drive(0, 0, 1, 32'h5000, 64'h51_00000050, 2'b11, 2'd0);
    #1;
    check("latency out_valid", 64'(bus.out_valid), 0);
    check("latency count", 64'(bus.count), 0);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0, '0);
    #1;
    check("latency next count", 64'(bus.count), 2);
    check("latency next out_pc_0", 64'(bus.out_pc_0), 32'h5000);
    check("latency next out_inst_0", 64'(bus.out_inst_0), 32'h50);
    check("latency next out_pc_1", 64'(bus.out_pc_1), 32'h5004);
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0, 2'd2);
`endif
    @(negedge clk);
    drive(0, 0, 0, '0, '0, '0, '0);
    #1;
    check("drain count", 64'(bus.count), 0);

    // Randomized traffic: the bench plays an in-order cache that honours req_ready.
    do_reset();
    mq.delete();
    m_infl = 0;
    m_drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      r_fl   = (m_drop == 0) && ($urandom_range(99) < 3);
      r_rdy  = (int'(DEPTH) - mq.size() - 2 * m_infl >= 2) && (m_infl < int'(MAX));
      r_rf   = r_rdy && ($urandom_range(1) == 1);
      r_rv   = (m_infl + m_drop > 0) && ($urandom_range(1) == 1);
      r_pc   = $urandom & 32'hFFFF_FFFC;
      r_data = {$urandom, $urandom};
      r_mask = 2'($urandom_range(3));
      r_enq  = r_rv && (m_drop == 0);

      rl.delete();
      if (r_mask[0]) begin e.pc = r_pc; e.inst = r_data[31:0]; rl.push_back(e); end
      if (r_mask[1]) begin e.pc = r_pc + 32'd4; e.inst = r_data[63:32]; rl.push_back(e); end

      vis = mq;
`ifdef FETCH_QUEUE_BYPASS_EN
      if (mq.size() == 0 && r_enq) vis = rl;
`endif
      nvis  = (vis.size() > 2) ? 2 : vis.size();
      r_deq = 2'($urandom_range(nvis));

      drive(r_fl, r_rf, r_rv, r_pc, r_data, r_mask, r_deq);
      #1;
      check("rand count", 64'(bus.count), 64'(mq.size()));
      check("rand req_ready", 64'(bus.req_ready), 64'(r_rdy));
      check("rand out_valid", 64'(bus.out_valid), (nvis == 2) ? 3 : 64'(nvis));
      check("rand out_pc_0", 64'(bus.out_pc_0), (nvis >= 1) ? 64'(vis[0].pc) : 0);
      check("rand out_inst_0", 64'(bus.out_inst_0), (nvis >= 1) ? 64'(vis[0].inst) : 0);
      check("rand out_pc_1", 64'(bus.out_pc_1), (nvis == 2) ? 64'(vis[1].pc) : 0);
      check("rand out_inst_1", 64'(bus.out_inst_1), (nvis == 2) ? 64'(vis[1].inst) : 0);

      if (r_fl) begin
        mq.delete();
        m_drop = m_infl - (r_rv ? 1 : 0);
        m_infl = r_rf ? 1 : 0;
      end else begin
        if (r_rv) begin
          if (m_drop > 0) m_drop--;
          else begin
            m_infl--;
            foreach (rl[k]) mq.push_back(rl[k]);
          end
        end
        repeat (int'(r_deq)) void'(mq.pop_front());
        if (r_rf) m_infl++;
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
